stage_flow_ctrl: RTL and testbench

//  Parametrised game-flow controller: title -> N stages -> success/fail -> staff screens.

---
 rtl/game_pkg.sv | 46 ++++
 rtl/stage_timer.sv | 35 +++
 rtl/stage_flow_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_stage_flow_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: flow states, key classes
// and the PS/2 set-2 make codes the controller reacts to.
package game_pkg;

  localparam int TIME_W = 7;

  typedef enum logic [2:0] {
    TITLE   = 3'd0,
    LOAD    = 3'd1,
    PLAY    = 3'd2,
    SUCCESS = 3'd3,
    FAIL    = 3'd4,
    STAFF   = 3'd5
  } flow_state_t;

  typedef enum logic [3:0] {
    KC_NONE,
    KC_DIGIT,
    KC_UP,
    KC_LEFT,
    KC_DOWN,
    KC_RIGHT,
    KC_NEXT,
    KC_BACK,
    KC_RETRY
  } key_class_t;

  // Bit 8 is the extended-code flag; all keys used here are non-extended.
  localparam logic [8:0] SC_1 = 9'h016;
  localparam logic [8:0] SC_2 = 9'h01E;
  localparam logic [8:0] SC_3 = 9'h026;
  localparam logic [8:0] SC_4 = 9'h025;
  localparam logic [8:0] SC_5 = 9'h02E;
  localparam logic [8:0] SC_6 = 9'h036;
  localparam logic [8:0] SC_7 = 9'h03D;
  localparam logic [8:0] SC_8 = 9'h03E;
  localparam logic [8:0] SC_9 = 9'h046;
  localparam logic [8:0] SC_W = 9'h01D;
  localparam logic [8:0] SC_A = 9'h01C;
  localparam logic [8:0] SC_S = 9'h01B;
  localparam logic [8:0] SC_D = 9'h023;
  localparam logic [8:0] SC_N = 9'h031;
  localparam logic [8:0] SC_B = 9'h032;
  localparam logic [8:0] SC_R = 9'h02D;

endpackage

// File: rtl/stage_timer.sv
// Per-stage countdown: loads the time budget on stage entry, counts tick pulses
// down to zero and flags the tick that consumes the last unit.
module stage_timer
  import game_pkg::*;
#(
  parameter int LIMIT = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              timed,
  input  logic              enable,
  input  logic              tick,
  output logic [TIME_W-1:0] count,
  output logic              expire
);

  localparam logic [TIME_W-1:0] LIMIT_V = TIME_W'(LIMIT);

  logic dec;

  assign dec    = enable && tick && (count != '0);
  assign expire = dec && (count == TIME_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= timed ? LIMIT_V : '0;
    end else if (dec) begin
      count <= count - TIME_W'(1);
    end
  end

endmodule

// File: rtl/stage_flow_ctrl.sv
// Game-flow controller: title screen, stage selection, player movement, key
// pickup, goal detection and stage timing, driven by decoded PS/2 make events.
module stage_flow_ctrl
  import game_pkg::*;
#(
  parameter int                    N_STAGES   = 3,
  parameter int                    POS_W      = 9,
  parameter int                    MAX_X      = 304,
  parameter int                    MAX_Y      = 224,
  parameter int                    STEP       = 16,
  parameter int                    TIME_LIMIT = 60,
  parameter logic [N_STAGES-1:0]   TIMED_MASK = 3'b100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_make,
  input  logic [8:0]          key_code,
  input  logic                tick,
  input  logic [POS_W-1:0]    lvl_start_x,
  input  logic [POS_W-1:0]    lvl_start_y,
  input  logic [POS_W-1:0]    lvl_key_x,
  input  logic [POS_W-1:0]    lvl_key_y,
  input  logic [POS_W-1:0]    lvl_goal_x,
  input  logic [POS_W-1:0]    lvl_goal_y,
  output flow_state_t         state,
  output logic [3:0]          stage_idx,
  output logic [N_STAGES-1:0] unlocked,
  output logic [POS_W-1:0]    player_x,
  output logic [POS_W-1:0]    player_y,
  output logic                has_key,
  output logic [TIME_W-1:0]   time_left
);

  localparam logic [POS_W-1:0] STEP_V  = POS_W'(STEP);
  localparam logic [POS_W-1:0] MAX_X_V = POS_W'(MAX_X);
  localparam logic [POS_W-1:0] MAX_Y_V = POS_W'(MAX_Y);
  localparam logic [3:0]       LAST_V  = 4'(N_STAGES - 1);

  function automatic logic [N_STAGES-1:0] onehot(input logic [3:0] idx);
    onehot = N_STAGES'(32'd1 << idx);
  endfunction

  flow_state_t         state_n;
  key_class_t          kc;
  logic [3:0]          digit;
  logic [3:0]          stage_n;
  logic [N_STAGES-1:0] unlocked_n;
  logic [POS_W-1:0]    px_n, py_n, mv_x, mv_y;
  logic [POS_W:0]      sum_x, sum_y;
  logic                has_key_n;
  logic                at_key, pass, expire, timed, is_last;

  always_comb begin
    kc    = KC_NONE;
    digit = 4'd0;
    if (key_make) begin
      case (key_code)
        SC_1: begin kc = KC_DIGIT; digit = 4'd1; end
        SC_2: begin kc = KC_DIGIT; digit = 4'd2; end
        SC_3: begin kc = KC_DIGIT; digit = 4'd3; end
        SC_4: begin kc = KC_DIGIT; digit = 4'd4; end
        SC_5: begin kc = KC_DIGIT; digit = 4'd5; end
        SC_6: begin kc = KC_DIGIT; digit = 4'd6; end
        SC_7: begin kc = KC_DIGIT; digit = 4'd7; end
        SC_8: begin kc = KC_DIGIT; digit = 4'd8; end
        SC_9: begin kc = KC_DIGIT; digit = 4'd9; end
        SC_W: kc = KC_UP;
        SC_A: kc = KC_LEFT;
        SC_S: kc = KC_DOWN;
        SC_D: kc = KC_RIGHT;
        SC_N: kc = KC_NEXT;
        SC_B: kc = KC_BACK;
        SC_R: kc = KC_RETRY;
        default: kc = KC_NONE;
      endcase
    end
  end

  // Candidate position after this cycle's move; sums carry one extra bit so
  // the clamp against MAX_X/MAX_Y cannot wrap.
  assign sum_x = {1'b0, player_x} + {1'b0, STEP_V};
  assign sum_y = {1'b0, player_y} + {1'b0, STEP_V};

  always_comb begin
    mv_x = player_x;
    mv_y = player_y;
    case (kc)
      KC_LEFT:  mv_x = (player_x < STEP_V) ? '0 : player_x - STEP_V;
      KC_RIGHT: mv_x = (sum_x > {1'b0, MAX_X_V}) ? MAX_X_V : sum_x[POS_W-1:0];
      KC_UP:    mv_y = (player_y < STEP_V) ? '0 : player_y - STEP_V;
      KC_DOWN:  mv_y = (sum_y > {1'b0, MAX_Y_V}) ? MAX_Y_V : sum_y[POS_W-1:0];
      default: ;
    endcase
  end

  // Checking both the current and the moved position means reaching the goal
  // still wins when the same cycle's tick would have expired the timer.
  assign at_key  = (player_x == lvl_key_x) && (player_y == lvl_key_y);
  assign pass    = has_key && (((player_x == lvl_goal_x) && (player_y == lvl_goal_y)) ||
                               ((mv_x == lvl_goal_x) && (mv_y == lvl_goal_y)));
  assign timed   = |(TIMED_MASK & onehot(stage_idx));
  assign is_last = (stage_idx >= LAST_V);

  always_comb begin
    state_n    = state;
    stage_n    = stage_idx;
    unlocked_n = unlocked;
    px_n       = player_x;
    py_n       = player_y;
    has_key_n  = has_key;
    case (state)
      TITLE: begin
        if (kc == KC_DIGIT && digit <= 4'(N_STAGES) &&
            |(unlocked & onehot(digit - 4'd1))) begin
          stage_n = digit - 4'd1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        px_n      = lvl_start_x;
        py_n      = lvl_start_y;
        has_key_n = 1'b0;
        state_n   = PLAY;
      end
      PLAY: begin
        px_n = mv_x;
        py_n = mv_y;
        if (at_key) has_key_n = 1'b1;
        if (pass) begin
          state_n    = SUCCESS;
          unlocked_n = unlocked | onehot(is_last ? stage_idx : stage_idx + 4'd1);
        end else if (expire) begin
          state_n = FAIL;
        end else if (kc == KC_BACK) begin
          state_n = TITLE;
        end
      end
      SUCCESS: begin
        if (kc == KC_NEXT) begin
          if (is_last) begin
            state_n = STAFF;
          end else begin
            stage_n = stage_idx + 4'd1;
            state_n = LOAD;
          end
        end else if (kc == KC_BACK) begin
          state_n = TITLE;
        end
      end
      FAIL: begin
        if (kc == KC_RETRY)     state_n = LOAD;
        else if (kc == KC_BACK) state_n = TITLE;
      end
      STAFF: begin
        if (kc == KC_BACK) state_n = TITLE;
      end
      default: state_n = TITLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TITLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_idx <= 4'd0;
      unlocked  <= N_STAGES'(1);
      player_x  <= '0;
      player_y  <= '0;
      has_key   <= 1'b0;
    end else begin
      stage_idx <= stage_n;
      unlocked  <= unlocked_n;
      player_x  <= px_n;
      player_y  <= py_n;
      has_key   <= has_key_n;
    end
  end

  stage_timer #(
    .LIMIT (TIME_LIMIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == LOAD),
    .timed  (timed),
    .enable (state == PLAY),
    .tick   (tick),
    .count  (time_left),
    .expire (expire)
  );

endmodule

// File: tb/tb_stage_flow_ctrl.sv
// Directed bench for stage_flow_ctrl: walks title, stage selection, movement
// clamping, key/goal pass, timeout, retry, staff screen and async reset.
module tb_stage_flow_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_make;
  logic [8:0]  key_code;
  logic        tick;
  logic [8:0]  lvl_start_x, lvl_start_y, lvl_key_x, lvl_key_y, lvl_goal_x, lvl_goal_y;
  flow_state_t state;
  logic [3:0]  stage_idx;
  logic [2:0]  unlocked;
  logic [8:0]  player_x, player_y;
  logic        has_key;
  logic [6:0]  time_left;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Level ROM: stage 0 key(16,0) goal(32,0); stage 1 start(32,32) key(48,32)
  // goal(48,48); stage 2 key(16,0) goal(16,16).
  always_comb begin
    lvl_start_x = 9'd0;  lvl_start_y = 9'd0;
    lvl_key_x   = 9'd16; lvl_key_y   = 9'd0;
    lvl_goal_x  = 9'd32; lvl_goal_y  = 9'd0;
    case (stage_idx)
      4'd1: begin
        lvl_start_x = 9'd32; lvl_start_y = 9'd32;
        lvl_key_x   = 9'd48; lvl_key_y   = 9'd32;
        lvl_goal_x  = 9'd48; lvl_goal_y  = 9'd48;
      end
      4'd2: begin
        lvl_goal_x = 9'd16; lvl_goal_y = 9'd16;
      end
      default: ;
    endcase
  end

  stage_flow_ctrl #(
    .N_STAGES(3), .POS_W(9), .MAX_X(304), .MAX_Y(224), .STEP(16),
    .TIME_LIMIT(3), .TIMED_MASK(3'b100)
  ) dut (
    .clk(clk), .rst(rst), .key_make(key_make), .key_code(key_code), .tick(tick),
    .lvl_start_x(lvl_start_x), .lvl_start_y(lvl_start_y),
    .lvl_key_x(lvl_key_x), .lvl_key_y(lvl_key_y),
    .lvl_goal_x(lvl_goal_x), .lvl_goal_y(lvl_goal_y),
    .state(state), .stage_idx(stage_idx), .unlocked(unlocked),
    .player_x(player_x), .player_y(player_y), .has_key(has_key), .time_left(time_left)
  );

  // One clock with the given inputs; entered and left on a falling edge.
  task automatic step(input logic mk, input logic [8:0] code, input logic tk);
    key_make = mk; key_code = code; tick = tk;
    @(negedge clk);
    key_make = 1'b0; key_code = 9'd0; tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; key_make = 1'b0; key_code = 9'd0; tick = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (state !== TITLE) begin miscompares++; $display("[TB] FAIL reset_state: got %0d want %0d", state, TITLE); end
    vectors++; if (stage_idx !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_stage: got %0d want 0", stage_idx); end
    vectors++; if (unlocked !== 3'b001) begin miscompares++; $display("[TB] FAIL reset_unlocked: got %b want 001", unlocked); end
    vectors++; if ({player_x, player_y} !== 18'd0) begin miscompares++; $display("[TB] FAIL reset_pos: got %0d/%0d want 0/0", player_x, player_y); end
    vectors++; if (has_key !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_key: got %b want 0", has_key); end
    vectors++; if (time_left !== 7'd0) begin miscompares++; $display("[TB] FAIL reset_time: got %0d want 0", time_left); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_title_filter;
    step(1'b1, SC_D, 1'b1);
    vectors++; if (player_x !== 9'd0) begin miscompares++; $display("[TB] FAIL title_move: got %0d want 0", player_x); end
    step(1'b1, SC_2, 1'b0);
    vectors++; if (state !== TITLE) begin miscompares++; $display("[TB] FAIL locked_digit: got %0d want %0d", state, TITLE); end
    step(1'b1, SC_9, 1'b0);
    vectors++; if (state !== TITLE) begin miscompares++; $display("[TB] FAIL range_digit: got %0d want %0d", state, TITLE); end
    step(1'b0, SC_1, 1'b0);
    vectors++; if (state !== TITLE) begin miscompares++; $display("[TB] FAIL no_make: got %0d want %0d", state, TITLE); end
  endtask

  task automatic test_start;
    step(1'b1, SC_1, 1'b0);
    vectors++; if (state !== LOAD) begin miscompares++; $display("[TB] FAIL start_load: got %0d want %0d", state, LOAD); end
    step(1'b0, 9'd0, 1'b0);
    vectors++; if (state !== PLAY) begin miscompares++; $display("[TB] FAIL start_play: got %0d want %0d", state, PLAY); end
    vectors++; if ({stage_idx, player_x, player_y} !== {4'd0, 9'd0, 9'd0}) begin miscompares++; $display("[TB] FAIL start_pos: got stage %0d pos %0d/%0d want 0 0/0", stage_idx, player_x, player_y); end
  endtask

  task automatic test_clamp;
    step(1'b1, SC_A, 1'b0);
    step(1'b1, SC_W, 1'b0);
    vectors++; if ({player_x, player_y} !== {9'd0, 9'd0}) begin miscompares++; $display("[TB] FAIL clamp_low: got %0d/%0d want 0/0", player_x, player_y); end
    step(1'b1, SC_S, 1'b0);
    repeat (3) step(1'b1, SC_D, 1'b0);
    vectors++; if ({player_x, player_y} !== {9'd48, 9'd16}) begin miscompares++; $display("[TB] FAIL move_d3: got %0d/%0d want 48/16", player_x, player_y); end
    repeat (20) step(1'b1, SC_D, 1'b0);
    vectors++; if (player_x !== 9'd304) begin miscompares++; $display("[TB] FAIL clamp_x: got %0d want 304", player_x); end
    repeat (20) step(1'b1, SC_S, 1'b0);
    vectors++; if (player_y !== 9'd224) begin miscompares++; $display("[TB] FAIL clamp_y: got %0d want 224", player_y); end
    vectors++; if (has_key !== 1'b0) begin miscompares++; $display("[TB] FAIL clamp_key: got %b want 0", has_key); end
    step(1'b1, SC_B, 1'b0);
    vectors++; if ({state, unlocked} !== {TITLE, 3'b001}) begin miscompares++; $display("[TB] FAIL abort: got %0d %b want %0d 001", state, unlocked, TITLE); end
  endtask

  task automatic test_pass;
    step(1'b1, SC_1, 1'b0);
    step(1'b0, 9'd0, 1'b0);
    step(1'b1, SC_D, 1'b0);
    vectors++; if ({player_x, has_key} !== {9'd16, 1'b0}) begin miscompares++; $display("[TB] FAIL pass_d1: got %0d %b want 16 0", player_x, has_key); end
    step(1'b1, SC_D, 1'b0);
    vectors++; if ({state, player_x, has_key} !== {PLAY, 9'd32, 1'b1}) begin miscompares++; $display("[TB] FAIL pass_d2: got %0d %0d %b want %0d 32 1", state, player_x, has_key, PLAY); end
    step(1'b0, 9'd0, 1'b0);
    vectors++; if ({state, unlocked} !== {SUCCESS, 3'b011}) begin miscompares++; $display("[TB] FAIL pass0: got %0d %b want %0d 011", state, unlocked, SUCCESS); end
  endtask

  task automatic test_next_stage;
    step(1'b1, SC_N, 1'b0);
    vectors++; if ({state, stage_idx} !== {LOAD, 4'd1}) begin miscompares++; $display("[TB] FAIL next_load: got %0d %0d want %0d 1", state, stage_idx, LOAD); end
    step(1'b0, 9'd0, 1'b0);
    vectors++; if ({player_x, player_y, time_left} !== {9'd32, 9'd32, 7'd0}) begin miscompares++; $display("[TB] FAIL s1_start: got %0d/%0d t%0d want 32/32 t0", player_x, player_y, time_left); end
    step(1'b1, SC_D, 1'b0);
    step(1'b1, SC_S, 1'b0);
    vectors++; if ({player_x, player_y, has_key} !== {9'd48, 9'd48, 1'b1}) begin miscompares++; $display("[TB] FAIL s1_move: got %0d/%0d %b want 48/48 1", player_x, player_y, has_key); end
    step(1'b0, 9'd0, 1'b0);
    vectors++; if ({state, unlocked} !== {SUCCESS, 3'b111}) begin miscompares++; $display("[TB] FAIL pass1: got %0d %b want %0d 111", state, unlocked, SUCCESS); end
  endtask

  task automatic test_timeout;
    step(1'b1, SC_N, 1'b0);
    step(1'b0, 9'd0, 1'b0);
    vectors++; if ({state, stage_idx, time_left} !== {PLAY, 4'd2, 7'd3}) begin miscompares++; $display("[TB] FAIL s2_start: got %0d %0d t%0d want %0d 2 t3", state, stage_idx, time_left, PLAY); end
    step(1'b0, 9'd0, 1'b1);
    step(1'b0, 9'd0, 1'b1);
    vectors++; if ({state, time_left} !== {PLAY, 7'd1}) begin miscompares++; $display("[TB] FAIL tick2: got %0d t%0d want %0d t1", state, time_left, PLAY); end
    step(1'b0, 9'd0, 1'b1);
    vectors++; if ({state, time_left} !== {FAIL, 7'd0}) begin miscompares++; $display("[TB] FAIL timeout: got %0d t%0d want %0d t0", state, time_left, FAIL); end
    step(1'b1, SC_D, 1'b1);
    vectors++; if ({state, time_left, player_x} !== {FAIL, 7'd0, 9'd0}) begin miscompares++; $display("[TB] FAIL idle_fail: got %0d t%0d x%0d want %0d t0 x0", state, time_left, player_x, FAIL); end
    step(1'b1, SC_R, 1'b0);
    vectors++; if ({state, stage_idx} !== {LOAD, 4'd2}) begin miscompares++; $display("[TB] FAIL retry_load: got %0d %0d want %0d 2", state, stage_idx, LOAD); end
    step(1'b0, 9'd0, 1'b0);
    vectors++; if ({state, time_left, has_key} !== {PLAY, 7'd3, 1'b0}) begin miscompares++; $display("[TB] FAIL retry_play: got %0d t%0d %b want %0d t3 0", state, time_left, has_key, PLAY); end
  endtask

  task automatic test_pass_beats_fail;
    step(1'b1, SC_D, 1'b0);
    step(1'b0, 9'd0, 1'b0);
    vectors++; if (has_key !== 1'b1) begin miscompares++; $display("[TB] FAIL s2_key: got %b want 1", has_key); end
    step(1'b0, 9'd0, 1'b1);
    step(1'b0, 9'd0, 1'b1);
    step(1'b1, SC_S, 1'b1);
    vectors++; if ({state, player_y, time_left} !== {SUCCESS, 9'd16, 7'd0}) begin miscompares++; $display("[TB] FAIL pass_vs_fail: got %0d y%0d t%0d want %0d y16 t0", state, player_y, time_left, SUCCESS); end
    vectors++; if (unlocked !== 3'b111) begin miscompares++; $display("[TB] FAIL unlock_sat: got %b want 111", unlocked); end
  endtask

  task automatic test_staff;
    step(1'b1, SC_N, 1'b0);
    vectors++; if (state !== STAFF) begin miscompares++; $display("[TB] FAIL staff: got %0d want %0d", state, STAFF); end
    step(1'b1, SC_B, 1'b0);
    vectors++; if ({state, unlocked, stage_idx} !== {TITLE, 3'b111, 4'd2}) begin miscompares++; $display("[TB] FAIL staff_back: got %0d %b %0d want %0d 111 2", state, unlocked, stage_idx, TITLE); end
  endtask

  task automatic test_async_reset;
    step(1'b1, SC_3, 1'b0);
    step(1'b0, 9'd0, 1'b0);
    step(1'b1, SC_D, 1'b0);
    vectors++; if ({state, player_x, time_left} !== {PLAY, 9'd16, 7'd3}) begin miscompares++; $display("[TB] FAIL s3_play: got %0d x%0d t%0d want %0d x16 t3", state, player_x, time_left, PLAY); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({state, unlocked, stage_idx} !== {TITLE, 3'b001, 4'd0}) begin miscompares++; $display("[TB] FAIL async_rst_flow: got %0d %b %0d want %0d 001 0", state, unlocked, stage_idx, TITLE); end
    vectors++; if ({player_x, player_y, has_key, time_left} !== {9'd0, 9'd0, 1'b0, 7'd0}) begin miscompares++; $display("[TB] FAIL async_rst_data: got %0d/%0d %b t%0d want 0/0 0 t0", player_x, player_y, has_key, time_left); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_title_filter;
    test_start;
    test_clamp;
    test_pass;
    test_next_stage;
    test_timeout;
    test_pass_beats_fail;
    test_staff;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
